// File: rtl/screen_arbiter.sv
// screen_arbiter: two-client round-robin arbiter in front of the single
// screen_writer port. Ownership runs from grant to the writer's done, so a
// bounding-box pass is never interleaved with another client's pass.
module screen_arbiter #(
    parameter int WIDTH        = 8,
    parameter int COLOUR_WIDTH = 3
) (
    input  logic                    clock,
    input  logic                    resetn,
    // client 0
    input  logic                    c0_screen_start,
    input  logic [COLOUR_WIDTH-1:0] c0_new_screen_colour,
    input  logic [WIDTH-1:0]        c0_screen_x_min,
    input  logic [WIDTH-1:0]        c0_screen_y_min,
    input  logic [WIDTH-1:0]        c0_screen_x_range,
    input  logic [WIDTH-1:0]        c0_screen_y_range,
    output logic                    c0_screen_done,
    // client 1
    input  logic                    c1_screen_start,
    input  logic [COLOUR_WIDTH-1:0] c1_new_screen_colour,
    input  logic [WIDTH-1:0]        c1_screen_x_min,
    input  logic [WIDTH-1:0]        c1_screen_y_min,
    input  logic [WIDTH-1:0]        c1_screen_x_range,
    input  logic [WIDTH-1:0]        c1_screen_y_range,
    output logic                    c1_screen_done,
    // broadcast back to both clients
    output logic [WIDTH-1:0]        cl_screen_x,
    output logic [WIDTH-1:0]        cl_screen_y,
    output logic [COLOUR_WIDTH-1:0] cl_old_screen_colour,
    // writer side
    output logic                    screen_start,
    output logic [COLOUR_WIDTH-1:0] new_screen_colour,
    output logic [WIDTH-1:0]        screen_x_min,
    output logic [WIDTH-1:0]        screen_y_min,
    output logic [WIDTH-1:0]        screen_x_range,
    output logic [WIDTH-1:0]        screen_y_range,
    input  logic [WIDTH-1:0]        screen_x,
    input  logic [WIDTH-1:0]        screen_y,
    input  logic [COLOUR_WIDTH-1:0] old_screen_colour,
    input  logic                    screen_done,
    // status
    output logic [1:0]              grant,
    output logic                    busy
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_OWN0 = 2'd1, S_OWN1 = 2'd2} state_t;

    state_t state, next_state;
    logic   last;   // client served most recently
    logic   sent;   // writer has seen a forwarded start in this ownership
    logic   done_ok;

    // a done only counts once the writer has actually been started
    assign done_ok = screen_done & sent;

    // writer read-back is shared by both clients regardless of owner
    assign cl_screen_x          = screen_x;
    assign cl_screen_y          = screen_y;
    assign cl_old_screen_colour = old_screen_colour;

    // state, round-robin pointer and start-seen flag
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            last  <= 1'b1;
            sent  <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == S_IDLE)
                sent <= 1'b0;
            else if (state != S_IDLE && screen_start)
                sent <= 1'b1;
            if (done_ok && state == S_OWN0)
                last <= 1'b0;
            else if (done_ok && state == S_OWN1)
                last <= 1'b1;
        end
    end

    // grant on request from idle; release only on the writer's done
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (c0_screen_start && c1_screen_start)
                    next_state = last ? S_OWN0 : S_OWN1;
                else if (c0_screen_start)
                    next_state = S_OWN0;
                else if (c1_screen_start)
                    next_state = S_OWN1;
            end
            S_OWN0:  if (done_ok) next_state = S_IDLE;
            S_OWN1:  if (done_ok) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // route the owner's request/window to the writer and the done back to it
    always_comb begin
        screen_start      = 1'b0;
        new_screen_colour = '0;
        screen_x_min      = '0;
        screen_y_min      = '0;
        screen_x_range    = '0;
        screen_y_range    = '0;
        c0_screen_done    = 1'b0;
        c1_screen_done    = 1'b0;
        grant             = 2'b00;
        busy              = 1'b0;
        case (state)
            S_OWN0: begin
                screen_start      = c0_screen_start;
                new_screen_colour = c0_new_screen_colour;
                screen_x_min      = c0_screen_x_min;
                screen_y_min      = c0_screen_y_min;
                screen_x_range    = c0_screen_x_range;
                screen_y_range    = c0_screen_y_range;
                c0_screen_done    = done_ok;
                grant             = 2'b01;
                busy              = 1'b1;
            end
            S_OWN1: begin
                screen_start      = c1_screen_start;
                new_screen_colour = c1_new_screen_colour;
                screen_x_min      = c1_screen_x_min;
                screen_y_min      = c1_screen_y_min;
                screen_x_range    = c1_screen_x_range;
                screen_y_range    = c1_screen_y_range;
                c1_screen_done    = done_ok;
                grant             = 2'b10;
                busy              = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_screen_arbiter.sv
// Bench for screen_arbiter: per-cycle vector table with a queue of expected
// results, plus hand sequences for reset behaviour.
module tb_screen_arbiter;

    localparam int W  = 8;
    localparam int CW = 3;

    logic          clock = 1'b0;
    logic          resetn;
    logic          c0_screen_start, c1_screen_start;
    logic [CW-1:0] c0_new_screen_colour, c1_new_screen_colour;
    logic [W-1:0]  c0_screen_x_min, c0_screen_y_min, c0_screen_x_range, c0_screen_y_range;
    logic [W-1:0]  c1_screen_x_min, c1_screen_y_min, c1_screen_x_range, c1_screen_y_range;
    logic          c0_screen_done, c1_screen_done;
    logic [W-1:0]  cl_screen_x, cl_screen_y;
    logic [CW-1:0] cl_old_screen_colour;
    logic          screen_start;
    logic [CW-1:0] new_screen_colour;
    logic [W-1:0]  screen_x_min, screen_y_min, screen_x_range, screen_y_range;
    logic [W-1:0]  screen_x, screen_y;
    logic [CW-1:0] old_screen_colour;
    logic          screen_done;
    logic [1:0]    grant;
    logic          busy;

    always #5 clock = ~clock;

    screen_arbiter #(.WIDTH(W), .COLOUR_WIDTH(CW)) dut (
        .clock(clock), .resetn(resetn),
        .c0_screen_start(c0_screen_start), .c0_new_screen_colour(c0_new_screen_colour),
        .c0_screen_x_min(c0_screen_x_min), .c0_screen_y_min(c0_screen_y_min),
        .c0_screen_x_range(c0_screen_x_range), .c0_screen_y_range(c0_screen_y_range),
        .c0_screen_done(c0_screen_done),
        .c1_screen_start(c1_screen_start), .c1_new_screen_colour(c1_new_screen_colour),
        .c1_screen_x_min(c1_screen_x_min), .c1_screen_y_min(c1_screen_y_min),
        .c1_screen_x_range(c1_screen_x_range), .c1_screen_y_range(c1_screen_y_range),
        .c1_screen_done(c1_screen_done),
        .cl_screen_x(cl_screen_x), .cl_screen_y(cl_screen_y),
        .cl_old_screen_colour(cl_old_screen_colour),
        .screen_start(screen_start), .new_screen_colour(new_screen_colour),
        .screen_x_min(screen_x_min), .screen_y_min(screen_y_min),
        .screen_x_range(screen_x_range), .screen_y_range(screen_y_range),
        .screen_x(screen_x), .screen_y(screen_y), .old_screen_colour(old_screen_colour),
        .screen_done(screen_done), .grant(grant), .busy(busy)
    );

    // client 0 colour follows the writer x coordinate: exercises the zero-latency path
    assign c0_new_screen_colour = screen_x[CW-1:0];

    // vector: inputs {c0 start, c1 start, writer done, perturb c1 data}
    //         outputs {grant[1:0], busy, screen_start, c0 done, c1 done}
    typedef struct packed {
        logic [3:0] in;
        logic [5:0] out;
    } vec_t;

    typedef struct {
        logic [5:0]  ctl;
        logic [34:0] data;
        logic [2*W+CW-1:0] cl;
    } exp_t;

    vec_t vecs [16];
    exp_t sb [$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // c1 window: the spec window, or scrambled values while it must be ignored
    task automatic set_c1(input logic alt);
        if (alt) begin
            c1_new_screen_colour = 3'b010;
            c1_screen_x_min = 8'd99;  c1_screen_y_min = 8'd77;
            c1_screen_x_range = 8'd55; c1_screen_y_range = 8'd44;
        end else begin
            c1_new_screen_colour = 3'b101;
            c1_screen_x_min = 8'd10;  c1_screen_y_min = 8'd5;
            c1_screen_x_range = 8'd3; c1_screen_y_range = 8'd2;
        end
    endtask

    function automatic logic [34:0] exp_data(input logic [1:0] g, input logic [W-1:0] sx);
        if (g == 2'b01) return {sx[CW-1:0], 8'd20, 8'd30, 8'd7, 8'd9};
        if (g == 2'b10) return {3'b101, 8'd10, 8'd5, 8'd3, 8'd2};
        return '0;
    endfunction

    function automatic logic [34:0] dut_data();
        return {new_screen_colour, screen_x_min, screen_y_min, screen_x_range, screen_y_range};
    endfunction

    function automatic logic [5:0] dut_ctl();
        return {grant, busy, screen_start, c0_screen_done, c1_screen_done};
    endfunction

    initial begin
        vecs[0]  = {4'b1110, 6'b01_1100}; // done before sent: ignored
        vecs[1]  = {4'b1001, 6'b01_1100}; // c1 perturbed while c0 owns
        vecs[2]  = {4'b1110, 6'b01_1110}; // c0 done forwarded
        vecs[3]  = {4'b0100, 6'b00_0000}; // mandatory idle cycle
        vecs[4]  = {4'b0100, 6'b10_1100}; // c1 granted
        vecs[5]  = {4'b1100, 6'b10_1100};
        vecs[6]  = {4'b1110, 6'b10_1101}; // c1 done forwarded
        vecs[7]  = {4'b1100, 6'b00_0000}; // tie: c0 wins (alternation)
        vecs[8]  = {4'b1101, 6'b01_1100};
        vecs[9]  = {4'b0101, 6'b01_1000}; // c0 drops start: ownership held
        vecs[10] = {4'b0001, 6'b01_1000};
        vecs[11] = {4'b0010, 6'b01_1010}; // writer done ends the pass
        vecs[12] = {4'b0010, 6'b00_0000}; // spurious done while idle
        vecs[13] = {4'b0000, 6'b00_0000};
        vecs[14] = {4'b1100, 6'b00_0000}; // tie: c1 wins this time
        vecs[15] = {4'b1100, 6'b10_1100};

        c0_screen_x_min = 8'd20; c0_screen_y_min = 8'd30;
        c0_screen_x_range = 8'd7; c0_screen_y_range = 8'd9;
        set_c1(1'b0);
        screen_x = 8'h3c; screen_y = 8'h11; old_screen_colour = 3'b110;
        screen_done = 1'b0;
        c0_screen_start = 1'b1; c1_screen_start = 1'b1;
        resetn = 1'b0;

        // reset held with both requests high
        repeat (2) @(negedge clock);
        #1;
        cmp("reset_ctl", 64'(dut_ctl()), 64'(6'b00_0000));
        cmp("reset_data", 64'(dut_data()), 64'(35'd0));
        @(negedge clock) resetn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            exp_t e;
            @(negedge clock);
            c0_screen_start = vecs[i].in[3];
            c1_screen_start = vecs[i].in[2];
            screen_done     = vecs[i].in[1];
            set_c1(vecs[i].in[0]);
            screen_x = W'($urandom); screen_y = W'($urandom); old_screen_colour = CW'($urandom);
            e.ctl  = vecs[i].out;
            e.data = exp_data(vecs[i].out[5:4], screen_x);
            e.cl   = {screen_x, screen_y, old_screen_colour};
            sb.push_back(e);
            #1;
            if (sb.size() == 0) begin
                cmp("sb_empty", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                cmp($sformatf("ctl[%0d]", i), 64'(dut_ctl()), 64'(e.ctl));
                cmp($sformatf("data[%0d]", i), 64'(dut_data()), 64'(e.data));
                cmp($sformatf("cl[%0d]", i), 64'({cl_screen_x, cl_screen_y, cl_old_screen_colour}), 64'(e.cl));
            end
        end

        // async reset in the middle of a c1 pass
        @(negedge clock);
        screen_done = 1'b0;
        #1;
        cmp("pre_reset_grant", 64'(grant), 64'(2'b10));
        resetn = 1'b0;
        #1;
        cmp("async_reset_ctl", 64'(dut_ctl()), 64'(6'b00_0000));
        cmp("async_reset_data", 64'(dut_data()), 64'(35'd0));
        @(negedge clock) resetn = 1'b1;
        c0_screen_start = 1'b0;
        @(negedge clock);
        #1;
        cmp("regrant_after_reset", 64'(grant), 64'(2'b10));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
